wts_adsr_key_controller_5ch: RTL and testbench

- Initiator side of the ADSR envelope generator's control interface.
- Holds per-channel ADSR parameter registers, adsr_en bits and a per-channel key state machine. All of these are written by the CPU register interface.
- For the channel selected by the time-multiplexed `active` slot index, it presents that channel's parameters and delivers queued key events as single-cycle pulses aligned to that channel's slot.

---
 rtl/wts_adsr_key_controller_5ch.sv | 229 ++++++++++++++++++++++
 tb/tb_wts_adsr_key_controller_5ch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wts_adsr_key_controller_5ch.sv
// ---------------------------------------------------------------------------
// wts_adsr_key_controller_5ch
//
// Initiator side of the ADSR envelope generator control interface. Holds the
// per-channel ADSR parameters, the adsr_en bits and a key state machine per
// channel, all written by the CPU. For the channel named by the time-
// multiplexed `active` slot it presents that channel's parameters and turns a
// queued key event into a single-cycle pulse aligned to that slot.
//
// Ports:
//   clk            system clock
//   nreset         asynchronous reset, active-low
//   active[2:0]    current slot, 0..CH_NUM-1 = channel, others = no operation
//   wr             CPU write strobe (one cycle per write)
//   wr_ch[2:0]     channel targeted by the write
//   wr_addr[2:0]   0 AR, 1 DR, 2 SR, 3 RR, 4 SL, 5 key command, 6 adsr_en
//   wr_data[7:0]   write data
//   ch_key_on      key-on pulse for the active channel
//   ch_key_release key-release pulse for the active channel
//   ch_key_off     key-off pulse for the active channel
//   adsr_en        adsr_en bit of the active channel (0 in no-op slots)
//   reg_ar/dr/sr/rr[7:0], reg_sl[5:0]  parameters of the active channel
//   key_pending[4:0]  bit n = channel n has an undelivered key event
//   key_held[4:0]     bit n = channel n key state is HELD
// ---------------------------------------------------------------------------
module wts_adsr_key_controller_5ch #(
  parameter int CH_NUM = 5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [2:0] active,
  input  logic       wr,
  input  logic [2:0] wr_ch,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ch_key_on,
  output logic       ch_key_release,
  output logic       ch_key_off,
  output logic       adsr_en,
  output logic [7:0] reg_ar,
  output logic [7:0] reg_dr,
  output logic [7:0] reg_sr,
  output logic [7:0] reg_rr,
  output logic [5:0] reg_sl,
  output logic [4:0] key_pending,
  output logic [4:0] key_held
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_REL  = 2'd2
  } key_st_t;

  // Encoding of a queued key event.
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_ON   = 2'd1;
  localparam logic [1:0] CMD_REL  = 2'd2;
  localparam logic [1:0] CMD_OFF  = 2'd3;

  localparam logic [2:0] CH_LIM = 3'(CH_NUM);

  // Priority: key_off > key_on > key_release; all-zero means no command.
  function automatic logic [1:0] decode_cmd(input logic [2:0] bits);
    if (bits[2]) begin
      return CMD_OFF;
    end else if (bits[0]) begin
      return CMD_ON;
    end else if (bits[1]) begin
      return CMD_REL;
    end else begin
      return CMD_NONE;
    end
  endfunction

  logic [7:0]        r_ar   [CH_NUM];
  logic [7:0]        r_dr   [CH_NUM];
  logic [7:0]        r_sr   [CH_NUM];
  logic [7:0]        r_rr   [CH_NUM];
  logic [5:0]        r_sl   [CH_NUM];
  logic [CH_NUM-1:0] r_en;
  logic [CH_NUM-1:0] r_pend;
  logic [1:0]        r_pcmd [CH_NUM];
  key_st_t           r_state[CH_NUM];

  logic [CH_NUM-1:0] w_pend_nxt;
  logic [1:0]        w_pcmd_nxt [CH_NUM];
  key_st_t           w_state_nxt[CH_NUM];

  logic       w_wr_ok;
  logic       w_key_wr;
  logic [1:0] w_cmd;

  assign w_wr_ok  = wr && (wr_ch < CH_LIM);
  assign w_key_wr = w_wr_ok && (wr_addr == 3'd5);
  assign w_cmd    = decode_cmd(wr_data[2:0]);

  // Parameter and adsr_en storage, written by the CPU.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_ar[i] <= 8'd0;
        r_dr[i] <= 8'd0;
        r_sr[i] <= 8'd0;
        r_rr[i] <= 8'd0;
        r_sl[i] <= 6'd0;
      end
      r_en <= {CH_NUM{1'b1}};
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_wr_ok && (wr_ch == 3'(i))) begin
          case (wr_addr)
            3'd0:    r_ar[i] <= wr_data;
            3'd1:    r_dr[i] <= wr_data;
            3'd2:    r_sr[i] <= wr_data;
            3'd3:    r_rr[i] <= wr_data;
            3'd4:    r_sl[i] <= wr_data[5:0];
            3'd6:    r_en[i] <= wr_data[0];
            default: ;  // key command handled by the FSM, 7 unused
          endcase
        end
      end
    end
  end

  // Key FSM state, pending flag and queued command per channel.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_state[i] <= ST_IDLE;
        r_pcmd[i]  <= CMD_NONE;
      end
      r_pend <= {CH_NUM{1'b0}};
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_pcmd[i]  <= w_pcmd_nxt[i];
      end
      r_pend <= w_pend_nxt;
    end
  end

  // Next key state: delivery clears pending, a queued write (re)sets it.
  // A write in the delivery cycle wins, so the new event waits for the next
  // slot while the old one is presented on the outputs this cycle.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      w_state_nxt[i] = r_state[i];
      w_pcmd_nxt[i]  = r_pcmd[i];
      w_pend_nxt[i]  = r_pend[i];
      if (active == 3'(i)) begin
        w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = r_pend[i];
      end
      if (w_key_wr && (wr_ch == 3'(i))) begin
        case (w_cmd)
          CMD_ON: begin
            w_state_nxt[i] = ST_HELD;
            w_pcmd_nxt[i]  = CMD_ON;
            w_pend_nxt[i]  = 1'b1;
          end
          CMD_OFF: begin
            w_state_nxt[i] = ST_IDLE;
            w_pcmd_nxt[i]  = CMD_OFF;
            w_pend_nxt[i]  = 1'b1;
          end
          CMD_REL: begin
            // Release only means something while the key is held.
            if (r_state[i] == ST_HELD) begin
              w_state_nxt[i] = ST_REL;
              w_pcmd_nxt[i]  = CMD_REL;
              w_pend_nxt[i]  = 1'b1;
            end else begin
              w_state_nxt[i] = r_state[i];
            end
          end
          default: w_state_nxt[i] = r_state[i];
        endcase
      end else begin
        w_state_nxt[i] = w_state_nxt[i];
      end
    end
  end

  // Slot-indexed selection of parameters and key pulses.
  always_comb begin
    ch_key_on      = 1'b0;
    ch_key_release = 1'b0;
    ch_key_off     = 1'b0;
    adsr_en        = 1'b0;
    reg_ar         = 8'd0;
    reg_dr         = 8'd0;
    reg_sr         = 8'd0;
    reg_rr         = 8'd0;
    reg_sl         = 6'd0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (active == 3'(i)) begin
        adsr_en = r_en[i];
        reg_ar  = r_ar[i];
        reg_dr  = r_dr[i];
        reg_sr  = r_sr[i];
        reg_rr  = r_rr[i];
        reg_sl  = r_sl[i];
        if (r_pend[i]) begin
          ch_key_on      = (r_pcmd[i] == CMD_ON);
          ch_key_release = (r_pcmd[i] == CMD_REL);
          ch_key_off     = (r_pcmd[i] == CMD_OFF);
        end else begin
          ch_key_on      = 1'b0;
        end
      end else begin
        adsr_en = adsr_en;
      end
    end
  end

  // Status vectors are always 5 bits wide; unused channels read 0.
  for (genvar g = 0; g < 5; g++) begin : g_stat
    if (g < CH_NUM) begin : g_live
      assign key_pending[g] = r_pend[g];
      assign key_held[g]    = (r_state[g] == ST_HELD);
    end else begin : g_dead
      assign key_pending[g] = 1'b0;
      assign key_held[g]    = 1'b0;
    end
  end

endmodule

// File: tb/tb_wts_adsr_key_controller_5ch.sv
module tb_wts_adsr_key_controller_5ch;

  logic       clk = 1'b0;
  logic       nreset;
  logic [2:0] active;
  logic       wr;
  logic [2:0] wr_ch;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       ch_key_on, ch_key_release, ch_key_off, adsr_en;
  logic [7:0] reg_ar, reg_dr, reg_sr, reg_rr;
  logic [5:0] reg_sl;
  logic [4:0] key_pending, key_held;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wts_adsr_key_controller_5ch #(.CH_NUM(5)) dut (
    .clk(clk), .nreset(nreset), .active(active), .wr(wr), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .ch_key_on(ch_key_on),
    .ch_key_release(ch_key_release), .ch_key_off(ch_key_off),
    .adsr_en(adsr_en), .reg_ar(reg_ar), .reg_dr(reg_dr), .reg_sr(reg_sr),
    .reg_rr(reg_rr), .reg_sl(reg_sl), .key_pending(key_pending),
    .key_held(key_held)
  );

  typedef struct {
    logic [2:0] act;
    logic       wr;
    logic [2:0] ch;
    logic [2:0] addr;
    logic [7:0] d;
    logic [51:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {on,rel,off,en,ar,dr,sr,rr,sl,pend,held}
  function automatic logic [51:0] mk(input logic on, input logic rel,
      input logic off, input logic en, input logic [7:0] ar,
      input logic [7:0] dr, input logic [7:0] sr, input logic [7:0] rr,
      input logic [5:0] sl, input logic [4:0] pend, input logic [4:0] held);
    return {on, rel, off, en, ar, dr, sr, rr, sl, pend, held};
  endfunction

  function automatic logic [51:0] outs();
    return {ch_key_on, ch_key_release, ch_key_off, adsr_en, reg_ar, reg_dr,
            reg_sr, reg_rr, reg_sl, key_pending, key_held};
  endfunction

  task automatic check(input string name, input logic [51:0] act_v,
                       input logic [51:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act_v, exp_v);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic w, input logic [2:0] c,
                       input logic [2:0] ad, input logic [7:0] d);
    active = a; wr = w; wr_ch = c; wr_addr = ad; wr_data = d;
  endtask

  task automatic add(input logic [2:0] a, input logic w, input logic [2:0] c,
                     input logic [2:0] ad, input logic [7:0] d,
                     input logic [51:0] e);
    vec_t v;
    v.act = a; v.wr = w; v.ch = c; v.addr = ad; v.d = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [51:0] p1;
    logic [51:0] z;
    z  = mk(1'b0,1'b0,1'b0,1'b1,8'd0,8'd0,8'd0,8'd0,6'd0,5'd0,5'd0);
    p1 = mk(1'b0,1'b0,1'b0,1'b1,8'd2,8'd3,8'd100,8'd4,6'd60,5'd0,5'd0);

    // Parameter writes to ch1 while slot 1 is active: old value shown.
    add(3'd1,1'b0,3'd0,3'd0,8'h00, z);
    add(3'd1,1'b1,3'd1,3'd0,8'd2,  z);
    add(3'd1,1'b1,3'd1,3'd1,8'd3,  mk(0,0,0,1,8'd2,8'd0,8'd0,8'd0,6'd0,5'd0,5'd0));
    add(3'd1,1'b1,3'd1,3'd2,8'd100,mk(0,0,0,1,8'd2,8'd3,8'd0,8'd0,6'd0,5'd0,5'd0));
    add(3'd1,1'b1,3'd1,3'd3,8'd4,  mk(0,0,0,1,8'd2,8'd3,8'd100,8'd0,6'd0,5'd0,5'd0));
    add(3'd1,1'b1,3'd1,3'd4,8'hFC, mk(0,0,0,1,8'd2,8'd3,8'd100,8'd4,6'd0,5'd0,5'd0));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1);
    add(3'd0,1'b0,3'd0,3'd0,8'h00, z);
    add(3'd5,1'b0,3'd0,3'd0,8'h00, mk(0,0,0,0,8'd0,8'd0,8'd0,8'd0,6'd0,5'd0,5'd0));
    add(3'd1,1'b1,3'd5,3'd0,8'd99, p1);   // channel out of range
    add(3'd1,1'b1,3'd1,3'd7,8'h55, p1);   // address 7 ignored
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1);
    // Key on / release on ch1.
    add(3'd1,1'b1,3'd1,3'd5,8'h01, p1);
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1 | mk(1,0,0,0,0,0,0,0,0,5'b00010,5'b00010));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1 | mk(0,0,0,0,0,0,0,0,0,5'b00000,5'b00010));
    add(3'd1,1'b1,3'd1,3'd5,8'h02, p1 | mk(0,0,0,0,0,0,0,0,0,5'b00000,5'b00010));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1 | mk(0,1,0,0,0,0,0,0,0,5'b00010,5'b00000));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1);
    // Release to idle ch2 ignored, then 0x07 gives key_off only.
    add(3'd2,1'b1,3'd2,3'd5,8'h02, z);
    add(3'd2,1'b0,3'd0,3'd0,8'h00, z);
    add(3'd2,1'b1,3'd2,3'd5,8'h07, z);
    add(3'd2,1'b0,3'd0,3'd0,8'h00, z | mk(0,0,1,0,0,0,0,0,0,5'b00100,5'b00000));
    add(3'd2,1'b0,3'd0,3'd0,8'h00, z);
    // adsr_en write.
    add(3'd1,1'b1,3'd1,3'd6,8'h00, p1);
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1 & ~mk(0,0,0,1,0,0,0,0,0,0,0));
    add(3'd1,1'b1,3'd1,3'd6,8'h01, p1 & ~mk(0,0,0,1,0,0,0,0,0,0,0));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1);
    // Delivery and new write to ch3 in the same cycle.
    add(3'd3,1'b1,3'd3,3'd5,8'h01, z);
    add(3'd3,1'b1,3'd3,3'd5,8'h04, z | mk(1,0,0,0,0,0,0,0,0,5'b01000,5'b01000));
    add(3'd3,1'b0,3'd0,3'd0,8'h00, z | mk(0,0,1,0,0,0,0,0,0,5'b01000,5'b00000));
    add(3'd3,1'b0,3'd0,3'd0,8'h00, z);
    // Retrigger while pending replaces the event.
    add(3'd3,1'b1,3'd3,3'd5,8'h01, z);
    add(3'd0,1'b1,3'd3,3'd5,8'h01, z | mk(0,0,0,0,0,0,0,0,0,5'b01000,5'b01000));
    add(3'd3,1'b0,3'd0,3'd0,8'h00, z | mk(1,0,0,0,0,0,0,0,0,5'b01000,5'b01000));
    add(3'd3,1'b0,3'd0,3'd0,8'h00, z | mk(0,0,0,0,0,0,0,0,0,5'b00000,5'b01000));
    add(3'd3,1'b1,3'd3,3'd5,8'h04, z | mk(0,0,0,0,0,0,0,0,0,5'b00000,5'b01000));
    add(3'd3,1'b0,3'd0,3'd0,8'h00, z | mk(0,0,1,0,0,0,0,0,0,5'b01000,5'b00000));
    add(3'd3,1'b0,3'd0,3'd0,8'h00, z);
    // Priority: on beats release, off beats release.
    add(3'd1,1'b1,3'd1,3'd5,8'h03, p1);
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1 | mk(1,0,0,0,0,0,0,0,0,5'b00010,5'b00010));
    add(3'd1,1'b1,3'd1,3'd5,8'h06, p1 | mk(0,0,0,0,0,0,0,0,0,5'b00000,5'b00010));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1 | mk(0,0,1,0,0,0,0,0,0,5'b00010,5'b00000));
    add(3'd1,1'b0,3'd0,3'd0,8'h00, p1);

    // Reset.
    nreset = 1'b0;
    drive(3'd1, 1'b0, 3'd0, 3'd0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("reset_idle_c%0d", c), outs(), z);
    end
    next_cycle();

    // Table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].act, vecs[i].wr, vecs[i].ch, vecs[i].addr, vecs[i].d);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      next_cycle();
    end

    // Rotating slots: key_on to ch3 written in slot 0 pulses only in slot 3.
    for (int c = 0; c < 12; c++) begin
      if (c == 0) drive(3'd0, 1'b1, 3'd3, 3'd5, 8'h01);
      else        drive(3'(c % 6), 1'b0, 3'd0, 3'd0, 8'h00);
      @(negedge clk);
      check($sformatf("rotate_c%0d", c),
            {49'd0, ch_key_on, ch_key_release, ch_key_off},
            {49'd0, (c == 3), 1'b0, 1'b0});
      next_cycle();
    end

    // Reset mid-operation discards a pending key_on on ch4.
    drive(3'd0, 1'b1, 3'd4, 3'd5, 8'h01);
    next_cycle();
    drive(3'd0, 1'b0, 3'd0, 3'd0, 8'h00);
    @(negedge clk);
    check("pre_reset_status", {42'd0, key_pending, key_held},
          {42'd0, 5'b10000, 5'b11000});
    next_cycle();
    nreset = 1'b0;
    #1;
    check("in_reset", outs(), z);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(3'(c % 6), 1'b0, 3'd0, 3'd0, 8'h00);
      @(negedge clk);
      check($sformatf("post_reset_c%0d", c), outs(),
            mk(0,0,0,((c % 6) < 5),8'd0,8'd0,8'd0,8'd0,6'd0,5'd0,5'd0));
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
